// File: rtl/enc_dec_pkg.sv
// Shared SECDED constants: format codes, per-format bit counts and the
// Hamming column assignment used by both encoder and decoder.
package enc_dec_pkg;

    typedef enum logic [1:0] {
        W8    = 2'b00,
        W16   = 2'b01,
        W32   = 2'b10,
        W_ILL = 2'b11
    } cw_fmt_e;

    localparam int unsigned D_BITS_8   = 4;
    localparam int unsigned D_BITS_16  = 11;
    localparam int unsigned D_BITS_32  = 26;
    localparam int unsigned C_BITS_8   = 4;
    localparam int unsigned C_BITS_16  = 5;
    localparam int unsigned C_BITS_32  = 6;
    localparam int unsigned MAX_D_BITS = 26;
    localparam int unsigned MAX_C_BITS = 6;

    // Column of data bit j: the j-th integer >= 3 that is not a power of two.
    function automatic logic [5:0] col_value(input int unsigned j);
        logic [5:0]  v;
        logic        found;
        int unsigned idx;
        v     = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned n = 3; n < 64; n++) begin
            if (!found && ((n & (n - 1)) != 0)) begin
                if (idx == j) begin
                    v     = n[5:0];
                    found = 1'b1;
                end
                idx++;
            end
        end
        return v;
    endfunction

    // Bits occupied by a codeword of the given format; illegal format owns none.
    function automatic logic [31:0] fmt_mask(input logic [1:0] w);
        logic [31:0] m;
        case (w)
            W8:      m = 32'h0000_00FF;
            W16:     m = 32'h0000_FFFF;
            W32:     m = 32'hFFFF_FFFF;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/enc_parity_gen.sv
// Combinational SECDED encoder: right-aligned data + format code to a
// right-aligned codeword (check bits low, data above, zero above format).
module enc_parity_gen
    import enc_dec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [MAX_D_BITS-1:0] data,
    input  logic [1:0]            width,
    output logic [DATA_WIDTH-1:0] codeword
);

    logic [31:0] raw;

    function automatic logic [31:0] encode(
        input logic [MAX_D_BITS-1:0] d,
        input int unsigned           nd,
        input int unsigned           k
    );
        logic [31:0] cw;
        logic [5:0]  v;
        logic        chk;
        logic        par;
        cw  = '0;
        par = 1'b0;
        for (int unsigned j = 0; j < MAX_D_BITS; j++) begin
            if (j < nd) begin
                cw[5'(k + j)] = d[5'(j)];
                par ^= d[5'(j)];
            end
        end
        // Hamming checks occupy bits 0..k-2; overall parity closes at bit k-1.
        for (int unsigned i = 0; i < MAX_C_BITS - 1; i++) begin
            if (i < k - 1) begin
                chk = 1'b0;
                for (int unsigned j = 0; j < MAX_D_BITS; j++) begin
                    if (j < nd) begin
                        v = col_value(j);
                        chk ^= d[5'(j)] & v[3'(i)];
                    end
                end
                cw[5'(i)] = chk;
                par ^= chk;
            end
        end
        cw[5'(k - 1)] = par;
        return cw;
    endfunction

    always_comb begin
        raw = '0;
        case (width)
            W8:      raw = encode(data, D_BITS_8,  C_BITS_8);
            W16:     raw = encode(data, D_BITS_16, C_BITS_16);
            W32:     raw = encode(data, D_BITS_32, C_BITS_32);
            default: raw = '0;
        endcase
        codeword       = '0;
        codeword[31:0] = raw;
    end

endmodule

// File: rtl/hamming_encoder_pipe.sv
// Two-stage valid/ready SECDED encoder with saturating delivery count.
// Optional error injection input enabled by HAMMING_ENC_ERR_INJ_EN.
module hamming_encoder_pipe
    import enc_dec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            codeword_width,
    input  logic [DATA_WIDTH-1:0] data_in,
`ifdef HAMMING_ENC_ERR_INJ_EN
    input  logic [DATA_WIDTH-1:0] inj_mask,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] codeword,
    output logic [1:0]            out_width,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  enc_count,
    output logic                  width_err
);

    logic                  s1_valid;
    logic [MAX_D_BITS-1:0] s1_data;
    logic [1:0]            s1_width;
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_codeword;
    logic [1:0]            s2_width;
    logic [DATA_WIDTH-1:0] enc_word;
    logic [DATA_WIDTH-1:0] s2_next;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  err;
    logic                  s1_advance;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  unused_data_hi;

    // Data above the widest format never reaches the encoder.
    assign unused_data_hi = ^data_in[DATA_WIDTH-1:MAX_D_BITS];

    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = rst && enable && (!s1_valid || s1_advance);
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = s2_valid && out_ready;

    enc_parity_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_gen (
        .data     (s1_data),
        .width    (s1_width),
        .codeword (enc_word)
    );

`ifdef HAMMING_ENC_ERR_INJ_EN
    logic [DATA_WIDTH-1:0] s1_mask;
    logic [DATA_WIDTH-1:0] fmt_bits;

    always_comb begin
        fmt_bits       = '0;
        fmt_bits[31:0] = fmt_mask(s1_width);
        s2_next        = enc_word ^ (s1_mask & fmt_bits);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_mask <= '0;
        end else if (in_xfer) begin
            s1_mask <= inj_mask;
        end
    end
`else
    assign s2_next = enc_word;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_width <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_data  <= data_in[MAX_D_BITS-1:0];
            s1_width <= codeword_width;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 only loads when it is empty or being drained, so a stalled word holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid    <= 1'b0;
            s2_codeword <= '0;
            s2_width    <= '0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_codeword <= s2_next;
                s2_width    <= s1_width;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (out_xfer && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
            if (in_xfer && (codeword_width == W_ILL)) begin
                err <= 1'b1;
            end
        end
    end

    assign codeword  = s2_codeword;
    assign out_width = s2_width;
    assign out_valid = s2_valid;
    assign enc_count = cnt;
    assign width_err = err;

endmodule

// File: tb/tb_hamming_encoder_pipe.sv
// Scoreboard bench for hamming_encoder_pipe: directed vectors with
// hand-computed codewords, backpressure, illegal width, reset flush.
module tb_hamming_encoder_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;
    localparam int unsigned CNT_SAT = 7;

    typedef struct {
        logic [DW-1:0] cw;
        logic [1:0]    w;
    } exp_t;

    typedef struct {
        logic [1:0]    w;
        logic [DW-1:0] d;
        logic [DW-1:0] cw;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [1:0]    codeword_width;
    logic [DW-1:0] data_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] codeword;
    logic [1:0]    out_width;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] enc_count;
    logic          width_err;
`ifdef HAMMING_ENC_ERR_INJ_EN
    logic [DW-1:0] inj_mask = '0;
`endif

    exp_t        exp_q[$];
    int unsigned checks  = 0;
    int unsigned errors  = 0;
    int unsigned n_deliv = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_cw;
    logic [1:0]    prev_w;

    vec_t vecs[14] = '{
        '{2'b00, 32'h0000_000F, 32'h0000_00FF},
        '{2'b00, 32'h0000_0001, 32'h0000_001B},
        '{2'b00, 32'h0000_0000, 32'h0000_0000},
        '{2'b01, 32'h0000_0001, 32'h0000_0033},
        '{2'b10, 32'h0000_0000, 32'h0000_0000},
        '{2'b10, 32'h0000_0001, 32'h0000_0063},
        '{2'b01, 32'h0000_07FF, 32'h0000_FFFF},
        '{2'b00, 32'hFFFF_FFF8, 32'h0000_0087},
        '{2'b10, 32'h03FF_FFFF, 32'hFFFF_FFFF},
        '{2'b01, 32'h0000_0400, 32'h0000_801F},
        '{2'b10, 32'h0200_0000, 32'h8000_001F},
        '{2'b10, 32'h0000_0010, 32'h0000_0429},
        '{2'b00, 32'h0000_0002, 32'h0000_002D},
        '{2'b01, 32'hFFFF_F801, 32'h0000_0033}
    };

    always #5 clk = ~clk;

    hamming_encoder_pipe #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .codeword_width (codeword_width),
        .data_in        (data_in),
`ifdef HAMMING_ENC_ERR_INJ_EN
        .inj_mask       (inj_mask),
`endif
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .codeword       (codeword),
        .out_width      (out_width),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .enc_count      (enc_count),
        .width_err      (width_err)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic int unsigned sat_cnt(input int unsigned n);
        return (n > CNT_SAT) ? CNT_SAT : n;
    endfunction

    // Monitor: sampled mid-low-phase, a valid&ready seen here transfers at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", DW'(out_valid), DW'(1));
                check("stall_codeword", codeword, prev_cw);
                check("stall_width", DW'(out_width), DW'(prev_w));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got codeword %h want no output", codeword);
                end else begin
                    e = exp_q.pop_front();
                    check("codeword", codeword, e.cw);
                    check("out_width", DW'(out_width), DW'(e.w));
                    n_deliv++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_cw    = codeword;
            prev_w     = out_width;
        end
    end

    task automatic send(input logic [1:0] w, input logic [DW-1:0] d, input logic [DW-1:0] cw);
        bit done;
        done           = 1'b0;
        codeword_width = w;
        data_in        = d;
        in_valid       = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                exp_q.push_back('{cw: cw, w: w});
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 for 50 cycles want 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words outstanding want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        #3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b0;
        enable         = 1'b1;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        codeword_width = 2'b00;
        data_in        = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_codeword", codeword, DW'(0));
        check("rst_out_width", DW'(out_width), DW'(0));
        check("rst_enc_count", DW'(enc_count), DW'(0));
        check("rst_width_err", DW'(width_err), DW'(0));
        check("rst_in_ready", DW'(in_ready), DW'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) send(vecs[i].w, vecs[i].d, vecs[i].cw);
        drain();
        check("enc_count_4", DW'(enc_count), DW'(sat_cnt(n_deliv)));
        check("enc_count_4_abs", DW'(enc_count), DW'(4));

        for (int i = 4; i < 14; i++) send(vecs[i].w, vecs[i].d, vecs[i].cw);
        drain();
        check("enc_count_sat", DW'(enc_count), DW'(CNT_SAT));

        // Backpressure: two words fill the pipe, the third must wait.
        @(negedge clk);
        out_ready = 1'b0;
        send(2'b00, 32'h0000_000F, 32'h0000_00FF);
        send(2'b01, 32'h0000_0001, 32'h0000_0033);
        codeword_width = 2'b10;
        data_in        = 32'h0000_0001;
        in_valid       = 1'b1;
        repeat (3) begin
            #1;
            check("bp_in_ready", DW'(in_ready), DW'(0));
            check("bp_out_valid", DW'(out_valid), DW'(1));
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(2'b10, 32'h0000_0001, 32'h0000_0063);
        enable = 1'b0;
        #1;
        check("disabled_in_ready", DW'(in_ready), DW'(0));
        drain();
        enable = 1'b1;

        send(2'b11, 32'hFFFF_FFFF, 32'h0000_0000);
        drain();
        check("width_err_set", DW'(width_err), DW'(1));
        send(2'b00, 32'h0000_0001, 32'h0000_001B);
        drain();
        check("width_err_held", DW'(width_err), DW'(1));

        // Reset with two words stalled in the pipe: they must never appear.
        @(negedge clk);
        out_ready = 1'b0;
        send(2'b00, 32'h0000_000F, 32'h0000_00FF);
        send(2'b00, 32'h0000_0001, 32'h0000_001B);
        rst = 1'b0;
        exp_q.delete();
        n_deliv = 0;
        repeat (2) @(negedge clk);
        #1;
        check("flush_out_valid", DW'(out_valid), DW'(0));
        check("flush_codeword", codeword, DW'(0));
        check("flush_enc_count", DW'(enc_count), DW'(0));
        check("flush_width_err", DW'(width_err), DW'(0));
        check("flush_in_ready", DW'(in_ready), DW'(0));
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        check("post_rst_out_valid", DW'(out_valid), DW'(0));
        send(2'b01, 32'h0000_0400, 32'h0000_801F);
        drain();
        check("post_rst_enc_count", DW'(enc_count), DW'(1));

`ifdef HAMMING_ENC_ERR_INJ_EN
        inj_mask = 32'h0000_0101;
        send(2'b00, 32'h0000_000F, 32'h0000_00FE);
        inj_mask = 32'h0001_0003;
        send(2'b01, 32'h0000_0001, 32'h0000_0030);
        inj_mask = '0;
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
